hc138_req_decoder: RTL and testbench
====================================

// Module: hc138_req_decoder
//
// PURPOSE
// - Decoder end of the hc148 priority-encoder interface: takes the active-low 3-bit code plus GS_N/EO_N
//   from an 8-line encoder and regenerates a single active-low request line (74HC138 style).
// - Adds a stability qualifier, a registered one-hot output, and an ack handshake, so each request
//   is presented to the downstream service logic exactly once.
// - Sits between the hc148 encoder and the interrupt/service sequencer on the same clock.
//
// PARAMETERS
// - STABLE_CYCLES  3  consecutive identical samples of code_N (with GS_N low, enabled) required before assert; legal 1..15
//
// PORTS
// - clk      in   1  single clock; all state on rising edge
// - rst      in   1  asynchronous, active-high reset
// - g1       in   1  enable, active high (138 G1)
// - g2a_N    in   1  enable, active low (138 G2A)
// - g2b_N    in   1  enable, active low (138 G2B)
// - code_N   in   3  encoder output, active-low binary; index = ~code_N
// - gs_N     in   1  encoder group-select, low = some request active
// - eo_N     in   1  encoder enable-out, low = encoder enabled and no request
// - ack      in   1  service logic accepts current request (level, sampled on clk)
// - y_N      out  8  decoded request lines, active low, at most one low
// - valid    out  1  high while a y_N line is low
// - idx      out  3  index of the asserted line, held while valid
// - idle_o   out  1  registered copy of ~eo_N & enabled: encoder reports no request
// - abort    out  1  one-cycle pulse: asserted request withdrawn by disable before ack
//
// BEHAVIOUR
// - Reset (async, any state): y_N=8'hFF, valid=0, idx=0, idle_o=0, abort=0, state=IDLE, cnt=0.
// - enabled = g1 & ~g2a_N & ~g2b_N. All outputs registered; no combinational input->output path.
// - IDLE: y_N=FF. If enabled & ~gs_N: cand<=code_N; STABLE_CYCLES==1 -> ASSERT directly, else cnt<=1, -> QUAL.
// - QUAL: !enabled or gs_N -> IDLE (no outputs). code_N!=cand -> cand<=code_N, cnt<=1.
//   Match and cnt==STABLE_CYCLES-1 -> ASSERT. Otherwise cnt<=cnt+1.
// - ASSERT entry edge: y_N[~cand]<=0, idx<=~cand, valid<=1. Latency: y_N low after STABLE_CYCLES edges
//   with a stable code. code_N/gs_N changes while in ASSERT are ignored; idx is held.
// - ASSERT: !enabled -> y_N<=FF, valid<=0, abort<=1 for one cycle, -> IDLE (disable wins over simultaneous ack).
//   ack (enabled) -> y_N<=FF, valid<=0, -> RELEASE.
// - RELEASE: waits for gs_N high or !enabled, then -> IDLE. A request still held is not re-asserted
//   until it drops, which prevents double service.
// - ack outside ASSERT is ignored. idle_o is updated every cycle in all states.
// - cnt width is 4 bits; no wrap is possible because STABLE_CYCLES<=15.
// - State encoding: IDLE=0, QUAL=1, ASSERT=2, RELEASE=3.
//
// STRUCTURE
// - Shared include hc_defs.vh: state encodings (IDLE/QUAL/ASSERT/RELEASE) and ALL_OFF=8'hFF, reused by
//   the hc148 side and the sequencer.
// - Single module. Contents: the FSM, the cand/cnt qualifier, and the one-hot output register.
//   No sub-module.
//
// TESTING
// - Reset mid-ASSERT: rst pulse -> y_N=FF, valid=0 immediately (async), IDLE after release.
// - Enabled, code_N=3'b000, gs_N=0 held, STABLE=3 -> after 3 edges y_N=8'h7F, idx=7, valid=1;
//   ack -> y_N=FF next edge, stays FF until gs_N=1.
// - code_N toggles 3'b101->3'b110 on 2nd QUAL cycle -> counter restarts; y_N=8'hFD (idx=1) after 3 more edges.
// - In ASSERT, drop g1 and raise ack on the same edge -> y_N=FF, abort=1 for one cycle, valid=0,
//   state IDLE (no RELEASE).
// - gs_N=1, eo_N=0, enabled -> idle_o=1, y_N=FF; g2b_N=1 -> idle_o=0; gs_N pulse shorter than
//   STABLE cycles -> no assert.
// - Sweep all 8 codes with ack handshake -> exactly one line low per request; one-hot checked every cycle.

Source files
------------

// File: rtl/hc138_req_decoder_pkg.sv
// Shared encodings for the hc148/hc138 request path: FSM states and the all-lines-off pattern.
// Also provides the active-low one-hot helper used by the decoder output register.
package hc138_req_decoder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUAL    = 2'd1;
  localparam logic [1:0] ST_ASSERT  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [7:0] ALL_OFF = 8'hFF;

  function automatic logic [7:0] onehot_n(input logic [2:0] line);
    onehot_n = ~(8'b0000_0001 << line);
  endfunction

endpackage

// File: rtl/hc138_req_decoder.sv
// Regenerates one active-low request line from the hc148 code after STABLE_CYCLES matching samples.
// The line drops STABLE_CYCLES edges after a stable code; ack retires it, and a disable retires it with an abort pulse.
module hc138_req_decoder
  import hc138_req_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       g1,
  input  logic       g2a_N,
  input  logic       g2b_N,
  input  logic [2:0] code_N,
  input  logic       gs_N,
  input  logic       eo_N,
  input  logic       ack,
  output logic [7:0] y_N,
  output logic       valid,
  output logic [2:0] idx,
  output logic       idle_o,
  output logic       abort
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] y_n_q, y_n_d;
  logic       valid_q, valid_d;
  logic [2:0] idx_q, idx_d;
  logic       idle_q, idle_d;
  logic       abort_q, abort_d;
  logic       enabled;

  always_comb begin
    enabled = g1 & ~g2a_N & ~g2b_N;
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    y_n_d   = y_n_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    abort_d = 1'b0;
    idle_d  = ~eo_N & enabled;

    case (state_q)
      ST_IDLE: begin
        if (enabled && !gs_N) begin
          cand_d = code_N;
          if (STABLE_CYCLES == 1) begin
            y_n_d   = onehot_n(~code_N);
            idx_d   = ~code_N;
            valid_d = 1'b1;
            state_d = ST_ASSERT;
          end else begin
            cnt_d   = 4'd1;
            state_d = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (!enabled || gs_N) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (code_N != cand_q) begin
          // A changed code restarts qualification on the new value.
          cand_d = code_N;
          cnt_d  = 4'd1;
        end else if (cnt_q == CNT_LAST) begin
          y_n_d   = onehot_n(~cand_q);
          idx_d   = ~cand_q;
          valid_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_ASSERT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ASSERT: begin
        // Disable takes priority over a coincident ack and is reported as an abort.
        if (!enabled) begin
          y_n_d   = ALL_OFF;
          valid_d = 1'b0;
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (ack) begin
          y_n_d   = ALL_OFF;
          valid_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (gs_N || !enabled) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= 3'd0;
      cnt_q   <= 4'd0;
      y_n_q   <= ALL_OFF;
      valid_q <= 1'b0;
      idx_q   <= 3'd0;
      idle_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      y_n_q   <= y_n_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      abort_q <= abort_d;
    end
  end

  assign y_N    = y_n_q;
  assign valid  = valid_q;
  assign idx    = idx_q;
  assign idle_o = idle_q;
  assign abort  = abort_q;

endmodule

// File: tb/tb_hc138_req_decoder.sv
// Bench for hc138_req_decoder: directed scenarios plus random traffic against a sample-history model.
module tb_hc138_req_decoder;

  localparam int STABLE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       g1, g2a_N, g2b_N;
  logic [2:0] code_N;
  logic       gs_N, eo_N, ack;
  logic [7:0] y_N;
  logic       valid;
  logic [2:0] idx;
  logic       idle_o;
  logic       abort;

  int checks = 0;
  int errors = 0;

  // Reference model: a request is granted once the most recent STABLE qualifying
  // samples (taken while armed) carry one identical code.
  int         m_mode;      // 0 armed, 1 granted, 2 serviced-awaiting-drop
  logic [2:0] hist[$];
  logic [7:0] m_y;
  logic       m_valid;
  logic [2:0] m_idx;
  logic       m_idle;
  logic       m_abort;

  hc138_req_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .g1(g1), .g2a_N(g2a_N), .g2b_N(g2b_N),
    .code_N(code_N), .gs_N(gs_N), .eo_N(eo_N), .ack(ack),
    .y_N(y_N), .valid(valid), .idx(idx), .idle_o(idle_o), .abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_mode = 0;
    hist.delete();
    m_y = 8'hFF;
    m_valid = 1'b0;
    m_idx = 3'd0;
    m_idle = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic model_step();
    bit en, q, same;
    logic [2:0] line;
    en = g1 && !g2a_N && !g2b_N;
    q = en && !gs_N;
    m_abort = 1'b0;
    m_idle = en && !eo_N;
    case (m_mode)
      0: begin
        if (q) begin
          hist.push_back(code_N);
          if (hist.size() >= STABLE) begin
            same = 1'b1;
            for (int i = hist.size() - STABLE; i < hist.size(); i++)
              if (hist[i] != code_N) same = 1'b0;
            if (same) begin
              line = ~code_N;
              m_idx = line;
              m_y = 8'hFF;
              m_y[line] = 1'b0;
              m_valid = 1'b1;
              m_mode = 1;
              hist.delete();
            end
          end
        end else begin
          hist.delete();
        end
      end
      1: begin
        if (!en) begin
          m_abort = 1'b1; m_valid = 1'b0; m_y = 8'hFF; m_mode = 0;
        end else if (ack) begin
          m_valid = 1'b0; m_y = 8'hFF; m_mode = 2;
        end
      end
      default: begin
        if (gs_N || !en) m_mode = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    g1 = 1'b1; g2a_N = 1'b0; g2b_N = 1'b0;
    code_N = 3'b111; gs_N = 1'b1; eo_N = 1'b1; ack = 1'b0;
    model_reset();
    #3;
    checks++;
    if (y_N !== 8'hFF || valid !== 1'b0 || idx !== 3'd0 || idle_o !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: y_N=%h valid=%b idx=%0d idle_o=%b abort=%b, want FF 0 0 0 0",
               y_N, valid, idx, idle_o, abort);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    checks++;
    if (y_N !== 8'hFF || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: y_N=%h valid=%b, want FF 0", y_N, valid);
    end
  endtask

  task automatic test_basic_assert();
    code_N = 3'b000; gs_N = 1'b0;
    tick(); tick();
    checks++;
    if (y_N !== 8'hFF || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: y_N=%h valid=%b after 2 edges, want FF 0", y_N, valid);
    end
    tick();
    checks++;
    if (y_N !== 8'h7F || idx !== 3'd7 || valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_assert: y_N=%h idx=%0d valid=%b, want 7F 7 1", y_N, idx, valid);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (y_N !== 8'hFF || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: y_N=%h valid=%b, want FF 0", y_N, valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (y_N !== 8'hFF || valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_no_reassert cyc %0d: y_N=%h valid=%b, want FF 0", i, y_N, valid);
      end
    end
    gs_N = 1'b1;
    tick(); tick();
  endtask

  task automatic test_code_toggle();
    code_N = 3'b101; gs_N = 1'b0;
    tick(); tick();
    code_N = 3'b110;
    tick(); tick();
    checks++;
    if (valid !== 1'b0 || y_N !== 8'hFF) begin
      errors++;
      $display("FAIL toggle_restart: y_N=%h valid=%b, want FF 0", y_N, valid);
    end
    tick();
    checks++;
    if (y_N !== 8'hFD || idx !== 3'd1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL toggle_assert: y_N=%h idx=%0d valid=%b, want FD 1 1", y_N, idx, valid);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    gs_N = 1'b1; tick(); tick();
  endtask

  task automatic test_abort();
    code_N = 3'b010; gs_N = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (y_N !== 8'hDF || idx !== 3'd5 || valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: y_N=%h idx=%0d valid=%b, want DF 5 1", y_N, idx, valid);
    end
    g1 = 1'b0; ack = 1'b1;
    tick();
    checks++;
    if (y_N !== 8'hFF || abort !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: y_N=%h abort=%b valid=%b, want FF 1 0", y_N, abort, valid);
    end
    g1 = 1'b1; ack = 1'b0;
    tick();
    checks++;
    if (abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_one_cycle: abort=%b, want 0", abort);
    end
    // Held request re-asserts only if the FSM went back to IDLE rather than RELEASE.
    tick(); tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd5) begin
      errors++;
      $display("FAIL abort_to_idle: valid=%b idx=%0d, want 1 5", valid, idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    gs_N = 1'b1; tick(); tick();
  endtask

  task automatic test_idle_and_glitch();
    gs_N = 1'b1; eo_N = 1'b0;
    tick();
    checks++;
    if (idle_o !== 1'b1 || y_N !== 8'hFF) begin
      errors++;
      $display("FAIL idle_set: idle_o=%b y_N=%h, want 1 FF", idle_o, y_N);
    end
    g2b_N = 1'b1;
    tick();
    checks++;
    if (idle_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled: idle_o=%b, want 0", idle_o);
    end
    g2b_N = 1'b0; eo_N = 1'b1;
    code_N = 3'b011; gs_N = 1'b0;
    for (int i = 0; i < STABLE - 1; i++) tick();
    gs_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || y_N !== 8'hFF) begin
        errors++;
        $display("FAIL short_pulse cyc %0d: y_N=%h valid=%b, want FF 0", i, y_N, valid);
      end
    end
  endtask

  task automatic test_reset_mid_assert();
    code_N = 3'b100; gs_N = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (valid !== 1'b1 || y_N !== 8'hF7) begin
      errors++;
      $display("FAIL rst_mid_setup: y_N=%h valid=%b, want F7 1", y_N, valid);
    end
    #2;
    rst = 1'b1; gs_N = 1'b1;
    #1;
    model_reset();
    checks++;
    if (y_N !== 8'hFF || valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: y_N=%h valid=%b, want FF 0", y_N, valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    gs_N = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      errors++;
      $display("FAIL rst_then_idle: valid=%b idx=%0d, want 1 3", valid, idx);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    gs_N = 1'b1; tick(); tick();
  endtask

  task automatic test_sweep();
    int n;
    logic [7:0] exp_y;
    logic [2:0] exp_idx;
    for (int c = 0; c < 8; c++) begin
      code_N = 3'(c); gs_N = 1'b0;
      exp_idx = 3'(7 - c);
      exp_y = 8'hFF;
      exp_y[exp_idx] = 1'b0;
      n = 0;
      while (valid !== 1'b1 && n < 10) begin
        tick();
        n++;
        checks++;
        if ($countones(~y_N) > 1 || (valid === 1'b1) != ($countones(~y_N) == 1)) begin
          errors++;
          $display("FAIL sweep_onehot code %0d: y_N=%h valid=%b", c, y_N, valid);
        end
      end
      checks++;
      if (n != STABLE || y_N !== exp_y || idx !== exp_idx) begin
        errors++;
        $display("FAIL sweep code %0d: edges=%0d y_N=%h idx=%0d, want %0d %h %0d",
                 c, n, y_N, idx, STABLE, exp_y, exp_idx);
      end
      ack = 1'b1; tick(); ack = 1'b0;
      gs_N = 1'b1; tick(); tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      g1    = ($urandom_range(0, 15) != 0);
      g2a_N = ($urandom_range(0, 20) == 0);
      g2b_N = ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 4) == 0) code_N = 3'($urandom);
      if ($urandom_range(0, 3) == 0) gs_N = ~gs_N;
      eo_N  = 1'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (y_N !== m_y || valid !== m_valid || idx !== m_idx || idle_o !== m_idle || abort !== m_abort) begin
        errors++;
        $display("FAIL random cyc %0d: y_N=%h valid=%b idx=%0d idle_o=%b abort=%b, want %h %b %0d %b %b",
                 i, y_N, valid, idx, idle_o, abort, m_y, m_valid, m_idx, m_idle, m_abort);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_assert();
    test_code_toggle();
    test_abort();
    test_idle_and_glitch();
    test_reset_mid_assert();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
